dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Downstream data-memory stage: takes the datapath's memory request (aluout address, writedata, memread/memwrite)
//  and performs it on a wait-stated single-master bus with req/ack handshake.
//  Returns load data on readdata and holds the processor via stall until the access completes.
//  Flags misaligned accesses, bus errors and timeouts on fault.
// PARAMETERS
//  TIMEOUT  16  cycles in REQ without bus_ack before the access is aborted (>=2)
//  CNT_W    5   width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset (0 = reset asserted)
//  memread    in   1   load request from control path
//  memwrite   in   1   store request from control path
//  addr       in   32  byte address (datapath aluout)
//  wdata      in   32  store data (datapath writedata)
//  readdata   out  32  load result to datapath result mux, registered
//  stall      out  1   freeze PC/regfile write while 1
//  fault      out  1   1-cycle pulse: misaligned, bus error or timeout
//  bus_req    out  1   bus request, held until bus_ack or abort
//  bus_we     out  1   1 = write, 0 = read; valid while bus_req
//  bus_addr   out  32  word address, addr[1:0] always 2'b00
//  bus_wdata  out  32  store data
//  bus_ack    in   1   slave completes access this cycle
//  bus_err    in   1   qualifies bus_ack: access failed
//  bus_rdata  in   32  read data, valid when bus_ack=1
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; readdata, bus_addr, bus_wdata = 0; bus_req, bus_we, fault, stall = 0.
//  Reset mid-access: bus_req drops immediately with no ack wait. No stall/fault until release.
//  Request: rq = memread|memwrite. If both are set, the access is a write.
//  States: IDLE, REQ, DONE.
//  IDLE: rq & addr[1:0]==0 -> latch addr, wdata, we; go REQ.
//    stall=1 combinationally in this same cycle.
//  IDLE: rq & addr[1:0]!=0 -> no bus cycle; fault=1 (combinational); stall=0; readdata unchanged.
//  REQ: bus_req=1, stall=1; counter increments each cycle.
//    bus_ack & !bus_err: on read, readdata<=bus_rdata; go DONE.
//    bus_ack & bus_err: readdata<=0 on read; error flag set; go DONE.
//    counter==TIMEOUT-1 & !bus_ack: drop bus_req; readdata<=0 on read; error flag set; go DONE.
//  DONE: stall=0 so the instruction commits; fault=error flag (registered pulse); -> IDLE.
//    Requests in DONE are ignored: they belong to the committing instruction.
//  Latency: aligned access with ack in the k-th REQ cycle stalls for k+1 cycles.
//    Zero-wait ack -> stall high 2 cycles, then DONE.
//  Stores never modify readdata. bus_addr/bus_wdata/bus_we hold their last values outside REQ.
//  bus_ack outside REQ is ignored.
//  Counter clears on every entry to REQ.
// STRUCTURE
//  Shared include mem_defs.v: state encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2),
//    DEFAULT_TIMEOUT=16, FAULT_RDATA=32'h0.
//  One sub-module: timeout_counter (CNT_W-bit, clear/enable inputs, async active-low reset, expired output).
//  Top holds the FSM, address/data latches and output logic.
// TESTING
//  Aligned load 0x100, ack on 1st REQ cycle, rdata=0xCAFEF00D
//    -> stall 2 cycles, readdata=0xCAFEF00D, fault=0.
//  Aligned store 0x204, wdata=0x12345678, ack after 3 waits
//    -> bus_we=1, bus_addr=0x204, stall 5 cycles, readdata unchanged.
//  Load from 0x103 -> no bus_req, fault=1 same cycle, stall=0.
//  Load with no ack, TIMEOUT=16
//    -> bus_req drops after 16 REQ cycles, readdata=0, fault pulse in DONE.
//  Load acked with bus_err=1 -> readdata=0, fault=1 for one cycle, back to IDLE.
//  reset=0 during REQ -> bus_req=0 and stall=0 immediately.
//    After release, a new load completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller:
// FSM state encoding, default timeout and the read data returned on a failed load.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DEFAULT_TIMEOUT = 16;
  localparam logic [31:0] FAULT_RDATA     = 32'h0;

  function automatic logic is_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_timeout_counter.sv
// Counts cycles spent waiting for a bus acknowledge; expired is high in the
// last cycle the controller is allowed to wait.
module timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory stage: runs the datapath's load/store on a req/ack bus and
// holds the processor with stall until the access has finished.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  state_t state;
  logic   rq;
  logic   aligned;
  logic   accept;
  logic   err_flag;
  logic   expired;

  assign rq      = memread | memwrite;
  assign aligned = is_aligned(addr[1:0]);
  assign accept  = (state == IDLE) && rq && aligned;

  timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (state == REQ),
    .expired (expired)
  );

  // A write wins when both request lines are set; stores leave readdata alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      readdata  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= wdata;
            bus_we    <= memwrite;
            err_flag  <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) begin
              readdata <= bus_err ? FAULT_RDATA : bus_rdata;
            end
            err_flag <= bus_err;
            state    <= DONE;
          end else if (expired) begin
            if (!bus_we) begin
              readdata <= FAULT_RDATA;
            end
            err_flag <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by reset so a held request cannot stall or fault while in reset.
  assign bus_req = (state == REQ);
  assign stall   = reset && (accept || (state == REQ));
  assign fault   = reset && (((state == IDLE) && rq && !aligned) ||
                             ((state == DONE) && err_flag));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed and random accesses are
// scored against a per-transaction model of stall length, fault and load data.
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] readdata;
  logic        stall;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  int          checksRun = 0;
  int          checksPassed = 0;
  int          checksFailed = 0;
  logic [31:0] expReaddata;

  dmem_access_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .readdata  (readdata),
    .stall     (stall),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksRun++;
    assert (observed === expected) checksPassed++;
    else begin
      checksFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One idle cycle with no request and stray bus activity.
  task automatic idleCycle(input string tag);
    @(negedge clk);
    memread   = 1'b0;
    memwrite  = 1'b0;
    bus_ack   = 1'($urandom);
    bus_err   = 1'($urandom);
    bus_rdata = $urandom;
    #1;
    checkOutput({tag, " idle stall"}, 32'(stall), 32'd0);
    checkOutput({tag, " idle fault"}, 32'(fault), 32'd0);
    checkOutput({tag, " idle bus_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, " idle readdata"}, readdata, expReaddata);
  endtask

  // Full access: waits = REQ cycles without ack before the acking one;
  // waits >= TIMEOUT means the slave never answers.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rdat, input int waits,
                               input logic err);
    logic timedOut;
    int   reqCycles;
    @(negedge clk);
    memread   = rd;
    memwrite  = wr;
    addr      = a;
    wdata     = wd;
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = $urandom;
    #1;
    if (a[1:0] != 2'b00) begin
      checkOutput({tag, " misaligned fault"}, 32'(fault), 32'd1);
      checkOutput({tag, " misaligned stall"}, 32'(stall), 32'd0);
      checkOutput({tag, " misaligned bus_req"}, 32'(bus_req), 32'd0);
      checkOutput({tag, " misaligned readdata"}, readdata, expReaddata);
    end else begin
      timedOut  = (waits >= TIMEOUT);
      reqCycles = timedOut ? TIMEOUT : waits + 1;
      checkOutput({tag, " accept stall"}, 32'(stall), 32'd1);
      checkOutput({tag, " accept bus_req"}, 32'(bus_req), 32'd0);
      checkOutput({tag, " accept fault"}, 32'(fault), 32'd0);
      for (int c = 1; c <= reqCycles; c++) begin
        @(negedge clk);
        if (!timedOut && c == reqCycles) begin
          bus_ack   = 1'b1;
          bus_err   = err;
          bus_rdata = rdat;
        end else begin
          bus_ack   = 1'b0;
          bus_err   = 1'($urandom);
          bus_rdata = $urandom;
        end
        #1;
        checkOutput($sformatf("%s req%0d bus_req", tag, c), 32'(bus_req), 32'd1);
        checkOutput($sformatf("%s req%0d stall", tag, c), 32'(stall), 32'd1);
        checkOutput($sformatf("%s req%0d fault", tag, c), 32'(fault), 32'd0);
        if (c == 1) begin
          checkOutput({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
          checkOutput({tag, " bus_we"}, 32'(bus_we), 32'(wr));
          checkOutput({tag, " bus_wdata"}, bus_wdata, wd);
        end
      end
      // Completion cycle: request still held, stray ack must be ignored.
      @(negedge clk);
      bus_ack   = 1'($urandom);
      bus_err   = 1'($urandom);
      bus_rdata = $urandom;
      if (!wr) expReaddata = (timedOut || err) ? 32'h0 : rdat;
      #1;
      checkOutput({tag, " done stall"}, 32'(stall), 32'd0);
      checkOutput({tag, " done bus_req"}, 32'(bus_req), 32'd0);
      checkOutput({tag, " done fault"}, 32'(fault), 32'(timedOut || err));
      checkOutput({tag, " done readdata"}, readdata, expReaddata);
      checkOutput({tag, " done bus_we"}, 32'(bus_we), 32'(wr));
    end
    idleCycle(tag);
  endtask

  initial begin
    reset       = 1'b0;
    memread     = 1'b1;
    memwrite    = 1'b0;
    addr        = 32'h0000_0003;
    wdata       = 32'h0;
    bus_ack     = 1'b0;
    bus_err     = 1'b0;
    bus_rdata   = 32'h0;
    expReaddata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset readdata", readdata, 32'h0);
    checkOutput("reset bus_addr", bus_addr, 32'h0);
    checkOutput("reset bus_wdata", bus_wdata, 32'h0);
    checkOutput("reset bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset bus_we", 32'(bus_we), 32'd0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset fault", 32'(fault), 32'd0);
    @(negedge clk);
    memread = 1'b0;
    reset   = 1'b1;

    applyStimulus("load0x100", 1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    applyStimulus("store0x204", 1'b0, 1'b1, 32'h204, 32'h1234_5678, 32'hDEAD_BEEF, 3, 1'b0);
    applyStimulus("load0x103", 1'b1, 1'b0, 32'h103, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus("loadtimeout", 1'b1, 1'b0, 32'h300, 32'h0, 32'h5555_AAAA, TIMEOUT + 4, 1'b0);
    applyStimulus("loadrefill", 1'b1, 1'b0, 32'h304, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
    applyStimulus("lastcycleack", 1'b1, 1'b0, 32'h308, 32'h0, 32'h7777_1111, TIMEOUT - 1, 1'b0);
    applyStimulus("loadbuserr", 1'b1, 1'b0, 32'h400, 32'h0, 32'hFFFF_FFFF, 2, 1'b1);
    applyStimulus("bothflags", 1'b1, 1'b1, 32'h500, 32'hA5A5_5A5A, 32'h1111_2222, 0, 1'b0);
    applyStimulus("storeerr", 1'b0, 1'b1, 32'h504, 32'h3C3C_C3C3, 32'h9999_9999, 1, 1'b1);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra;
      int          sel;
      int          w;
      ra  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      sel = $urandom_range(0, 2);
      w   = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : $urandom_range(0, 6);
      applyStimulus($sformatf("rand%0d", i), sel != 1, sel != 0, ra, $urandom,
                    $urandom, w, $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a load, with the request still held.
    @(negedge clk);
    memread  = 1'b1;
    memwrite = 1'b0;
    addr     = 32'h600;
    bus_ack  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("midreset pre bus_req", 32'(bus_req), 32'd1);
    reset = 1'b0;
    #1;
    expReaddata = 32'h0;
    checkOutput("midreset bus_req", 32'(bus_req), 32'd0);
    checkOutput("midreset stall", 32'(stall), 32'd0);
    checkOutput("midreset fault", 32'(fault), 32'd0);
    checkOutput("midreset readdata", readdata, expReaddata);
    @(negedge clk);
    #1;
    checkOutput("inreset stall", 32'(stall), 32'd0);
    memread = 1'b0;
    reset   = 1'b1;
    applyStimulus("afterreset", 1'b1, 1'b0, 32'h700, 32'h0, 32'h600D_CAFE, 2, 1'b0);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
